// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_types (package)
//  Description : Shared RV32I types: branch compare opcode enum (funct3
//                encoding) and the branch reservation-station entry record.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

    // Widest ROB tag an entry can hold. Narrower ROB_IDX_W values are
    // zero-extended into this field.
    localparam int RS_TAG_W = 5;

    typedef logic [RS_TAG_W-1:0] rs_tag_t;

    // Branch compare operations, encoded as the B-type funct3 field.
    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef struct packed {
        logic           valid;
        branch_funct3_t cmpop;
        rs_tag_t        rob;
        logic [31:0]    pc;
        logic [31:0]    imm;
        logic           a_rdy;
        logic [31:0]    a_val;
        rs_tag_t        a_tag;
        logic           b_rdy;
        logic [31:0]    b_val;
        rs_tag_t        b_tag;
    } branch_rs_entry_t;

endpackage : rv32i_types
`default_nettype wire

// File: rtl/cmp.sv
`default_nettype none
// ============================================================================
//  Module      : cmp
//  Description : RV32I branch comparator. br_en_o is the branch outcome,
//                qualified by valid_i.
//  Ports       : valid_i   - request qualifier
//                cmpop_i   - funct3 compare opcode
//                a_i, b_i  - rs1 / rs2 operand values
//                br_en_o   - branch taken
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp
    import rv32i_types::*;
(
    input  logic        valid_i,
    input  logic [2:0]  cmpop_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        br_en_o
);

    logic result;

    always_comb begin
        result = 1'b0;
        case (cmpop_i)
            beq:     result = (a_i == b_i);
            bne:     result = (a_i != b_i);
            blt:     result = ($signed(a_i) <  $signed(b_i));
            bge:     result = ($signed(a_i) >= $signed(b_i));
            bltu:    result = (a_i <  b_i);
            bgeu:    result = (a_i >= b_i);
            default: result = 1'b0;
        endcase
    end

    assign br_en_o = valid_i & result;

endmodule : cmp
`default_nettype wire

// File: rtl/branch_rs.sv
`default_nettype none
// ============================================================================
//  Module      : branch_rs
//  Description : Branch reservation station. Holds DEPTH branches waiting on
//                operands, wakes them from the CDB, issues the oldest ready
//                one to the comparator and registers the resolved result.
//  Ports       : clk, rst              - clock, async active-high reset
//                flush_i               - synchronous squash
//                disp_*_i / disp_ready_o - dispatch interface
//                cdb_*_i               - common data bus broadcast
//                res_*_o / res_ready_i - resolved-branch output handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_rs
    import rv32i_types::*;
#(
    parameter int DEPTH     = 4,
    parameter int ROB_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    // dispatch
    input  logic                 disp_valid_i,
    output logic                 disp_ready_o,
    input  logic [2:0]           disp_cmpop_i,
    input  logic [ROB_IDX_W-1:0] disp_rob_i,
    input  logic [31:0]          disp_pc_i,
    input  logic [31:0]          disp_imm_i,
    input  logic                 disp_a_rdy_i,
    input  logic [31:0]          disp_a_val_i,
    input  logic [ROB_IDX_W-1:0] disp_a_tag_i,
    input  logic                 disp_b_rdy_i,
    input  logic [31:0]          disp_b_val_i,
    input  logic [ROB_IDX_W-1:0] disp_b_tag_i,
    // common data bus
    input  logic                 cdb_valid_i,
    input  logic [ROB_IDX_W-1:0] cdb_tag_i,
    input  logic [31:0]          cdb_data_i,
    // result
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [ROB_IDX_W-1:0] res_rob_o,
    output logic                 res_taken_o,
    output logic [31:0]          res_target_o
);

    localparam int IDX_W = $clog2(DEPTH);

    if ((DEPTH < 2) || (DEPTH > 8) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("branch_rs: DEPTH must be a power of two in 2..8");
    end
    if (ROB_IDX_W > RS_TAG_W) begin : g_bad_tag
        $error("branch_rs: ROB_IDX_W exceeds entry tag width");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    branch_rs_entry_t ent_q [DEPTH];
    branch_rs_entry_t ent_d [DEPTH];

    // age_q[j][i] = 1 means entry j was dispatched before entry i.
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];

    logic                 res_valid_q, res_valid_d;
    logic                 res_taken_q, res_taken_d;
    logic [ROB_IDX_W-1:0] res_rob_q,   res_rob_d;
    logic [31:0]          res_target_q, res_target_d;

    // ------------------------------------------------------------------
    // Free-slot search: lowest free index at the start of the cycle
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] disp_idx;
    logic             any_free;

    always_comb begin
        disp_idx = '0;
        any_free = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                disp_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

    assign disp_ready_o = any_free;

    logic disp_fire;
    assign disp_fire = disp_valid_i && any_free && !flush_i;

    // ------------------------------------------------------------------
    // Select: oldest entry whose registered ready flags are both set
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] elig;
    logic [DEPTH-1:0] blocked;
    logic [IDX_W-1:0] sel_idx;
    logic             any_elig;

    always_comb begin
        elig     = '0;
        blocked  = '0;
        sel_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = ent_q[i].valid && ent_q[i].a_rdy && ent_q[i].b_rdy;
        end
        // An entry is blocked if any older entry is also eligible. The
        // diagonal is always zero, so no self-exclusion is needed.
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (elig[j] && age_q[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (elig[i] && !blocked[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign any_elig = |elig;

    logic sel_fire;
    assign sel_fire = any_elig && (!res_valid_q || res_ready_i) && !flush_i;

    // ------------------------------------------------------------------
    // Compare and target computation for the selected entry
    // ------------------------------------------------------------------
    logic br_en;

    cmp u_cmp (
        .valid_i (sel_fire),
        .cmpop_i (ent_q[sel_idx].cmpop),
        .a_i     (ent_q[sel_idx].a_val),
        .b_i     (ent_q[sel_idx].b_val),
        .br_en_o (br_en)
    );

    logic [31:0] sel_target;
    assign sel_target = br_en ? (ent_q[sel_idx].pc + ent_q[sel_idx].imm)
                              : (ent_q[sel_idx].pc + 32'd4);

    // ------------------------------------------------------------------
    // Entry / age next state
    // ------------------------------------------------------------------
    branch_rs_entry_t new_ent;
    logic             cdb_hit_a;
    logic             cdb_hit_b;

    assign cdb_hit_a = cdb_valid_i && (disp_a_tag_i == cdb_tag_i);
    assign cdb_hit_b = cdb_valid_i && (disp_b_tag_i == cdb_tag_i);

    always_comb begin
        new_ent       = '0;
        new_ent.valid = 1'b1;
        new_ent.cmpop = branch_funct3_t'(disp_cmpop_i);
        new_ent.rob   = rs_tag_t'(disp_rob_i);
        new_ent.pc    = disp_pc_i;
        new_ent.imm   = disp_imm_i;
        new_ent.a_tag = rs_tag_t'(disp_a_tag_i);
        new_ent.b_tag = rs_tag_t'(disp_b_tag_i);
        // A producer broadcasting in the dispatch cycle would otherwise be
        // missed, since the entry is not yet present to snoop the CDB.
        new_ent.a_rdy = disp_a_rdy_i || cdb_hit_a;
        new_ent.a_val = disp_a_rdy_i ? disp_a_val_i : (cdb_hit_a ? cdb_data_i : disp_a_val_i);
        new_ent.b_rdy = disp_b_rdy_i || cdb_hit_b;
        new_ent.b_val = disp_b_rdy_i ? disp_b_val_i : (cdb_hit_b ? cdb_data_i : disp_b_val_i);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            age_d[i] = age_q[i];
        end

        // Wakeup
        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_valid_i && ent_q[i].valid) begin
                if (!ent_q[i].a_rdy && (ent_q[i].a_tag == rs_tag_t'(cdb_tag_i))) begin
                    ent_d[i].a_rdy = 1'b1;
                    ent_d[i].a_val = cdb_data_i;
                end
                if (!ent_q[i].b_rdy && (ent_q[i].b_tag == rs_tag_t'(cdb_tag_i))) begin
                    ent_d[i].b_rdy = 1'b1;
                    ent_d[i].b_val = cdb_data_i;
                end
            end
        end

        if (sel_fire) begin
            ent_d[sel_idx].valid = 1'b0;
        end

        // Dispatch target was free at cycle start, so it never collides
        // with the selected entry.
        if (disp_fire) begin
            ent_d[disp_idx] = new_ent;
            for (int j = 0; j < DEPTH; j++) begin
                age_d[j][disp_idx] = 1'b1;
            end
            age_d[disp_idx] = '0;
        end

        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
                age_d[i]       = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result register next state
    // ------------------------------------------------------------------
    always_comb begin
        res_valid_d  = res_valid_q;
        res_taken_d  = res_taken_q;
        res_rob_d    = res_rob_q;
        res_target_d = res_target_q;
        if (flush_i) begin
            res_valid_d = 1'b0;
        end else if (sel_fire) begin
            res_valid_d  = 1'b1;
            res_taken_d  = br_en;
            res_rob_d    = ent_q[sel_idx].rob[ROB_IDX_W-1:0];
            res_target_d = sel_target;
        end else if (res_ready_i) begin
            res_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
                age_q[i] <= '0;
            end
            res_valid_q  <= 1'b0;
            res_taken_q  <= 1'b0;
            res_rob_q    <= '0;
            res_target_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
                age_q[i] <= age_d[i];
            end
            res_valid_q  <= res_valid_d;
            res_taken_q  <= res_taken_d;
            res_rob_q    <= res_rob_d;
            res_target_q <= res_target_d;
        end
    end

    assign res_valid_o  = res_valid_q;
    assign res_taken_o  = res_taken_q;
    assign res_rob_o    = res_rob_q;
    assign res_target_o = res_target_q;

endmodule : branch_rs
`default_nettype wire
